// File: rtl/rise_edge_detect.sv
// rise_edge_detect: per-bit rising-edge pulse generator with an any-edge summary and a wrapping edge-event counter.
// Define RISE_DETECT_SYNC_EN to insert a SYNC_STAGES-deep synchroniser ahead of the sample flops.
module rise_edge_detect #(
  parameter int DATA_WIDTH  = 1,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  cnt_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  any_out,
  output logic [CNT_WIDTH-1:0]  edge_cnt
);

  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("rise_edge_detect: DATA_WIDTH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("rise_edge_detect: SYNC_STAGES must be >= 2");
  end

  logic [DATA_WIDTH-1:0] smp_in;
  logic [DATA_WIDTH-1:0] smp_q;
  logic [DATA_WIDTH-1:0] hist_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_d;

`ifdef RISE_DETECT_SYNC_EN
  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= data_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign smp_in = sync_q[SYNC_STAGES-1];
`else
  assign smp_in = data_in;
`endif

  // Sample and history flops; the pulse is decoded purely from flop outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      smp_q  <= '0;
      hist_q <= '0;
    end else begin
      smp_q  <= smp_in;
      hist_q <= smp_q;
    end
  end

  assign data_out = smp_q & ~hist_q;
  assign any_out  = |data_out;

  // Clear wins over a same-cycle edge, so that edge is deliberately dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (any_out) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign edge_cnt = cnt_q;

endmodule

// File: tb/tb_rise_edge_detect.sv
// Directed bench for rise_edge_detect: DATA_WIDTH=4, CNT_WIDTH=4, SYNC_STAGES=3.
// Expected timing shifts by SYNC_STAGES cycles when RISE_DETECT_SYNC_EN is defined.
module tb_rise_edge_detect;

  localparam int DW  = 4;
  localparam int CW  = 4;
  localparam int SS  = 3;
`ifdef RISE_DETECT_SYNC_EN
  localparam int LAT = SS;
`else
  localparam int LAT = 0;
`endif

  logic          clk;
  logic          resetn;
  logic [DW-1:0] data_in;
  logic          cnt_clr;
  logic [DW-1:0] data_out;
  logic          any_out;
  logic [CW-1:0] edge_cnt;

  int checks   = 0;
  int failures = 0;

  rise_edge_detect #(
    .DATA_WIDTH (DW),
    .SYNC_STAGES(SS),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .data_in (data_in),
    .cnt_clr (cnt_clr),
    .data_out(data_out),
    .any_out (any_out),
    .edge_cnt(edge_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    repeat (LAT + 3) tick();
  endtask

  int            npulse;
  logic [15:0]   hist;
  logic [3:0]    pat;

  initial begin
    resetn  = 1'b1;
    data_in = '0;
    cnt_clr = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("rst_out", 32'(data_out), 32'h0);
    chk("rst_any", 32'(any_out), 32'h0);
    chk("rst_cnt", 32'(edge_cnt), 32'h0);

    // Input high while held in reset: nothing may appear.
    data_in = 4'b0001;
    repeat (LAT + 2) tick();
    chk("rst_hold_out", 32'(data_out), 32'h0);
    chk("rst_hold_cnt", 32'(edge_cnt), 32'h0);

    resetn = 1'b1;
    repeat (LAT) tick();
    chk("rel_pre_out", 32'(data_out), 32'h0);
    tick();
    chk("rel_pulse", 32'(data_out), 32'h1);
    chk("rel_any", 32'(any_out), 32'h1);
    chk("rel_cnt_lag", 32'(edge_cnt), 32'h0);
    tick();
    chk("rel_pulse_end", 32'(data_out), 32'h0);
    chk("rel_cnt", 32'(edge_cnt), 32'h1);

    // Level hold then fall.
    data_in = '0;
    flush();
    data_in = 4'b0001;
    repeat (LAT) tick();
    tick();
    chk("hold_pulse", 32'(data_out), 32'h1);
    npulse = 0;
    repeat (9) begin
      tick();
      if (data_out != '0) npulse++;
    end
    chk("hold_no_repulse", 32'(npulse), 32'd0);
    chk("hold_cnt", 32'(edge_cnt), 32'd2);
    data_in = '0;
    npulse = 0;
    repeat (LAT + 3) begin
      tick();
      if (data_out != '0) npulse++;
    end
    chk("fall_no_pulse", 32'(npulse), 32'd0);
    chk("fall_any", 32'(any_out), 32'h0);

    // Toggle 0,1,0,1 on consecutive edges.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_cnt", 32'(edge_cnt), 32'd0);
    pat  = 4'b1010;
    hist = '0;
    for (int i = 0; i < LAT + 6; i++) begin
      data_in = (i < 4) ? {3'b000, pat[i]} : 4'b0000;
      tick();
      hist[i] = data_out[0];
    end
    chk("toggle_pulses", 32'(hist), 32'(16'b1010 << LAT));
    chk("toggle_cnt", 32'(edge_cnt), 32'd2);

    // Multi-bit independence.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    data_in = 4'b0101;
    repeat (LAT) tick();
    tick();
    chk("mb_0101", 32'(data_out), 32'h5);
    chk("mb_any", 32'(any_out), 32'h1);
    tick();
    chk("mb_end", 32'(data_out), 32'h0);
    chk("mb_cnt1", 32'(edge_cnt), 32'd1);
    data_in = 4'b1111;
    repeat (LAT) tick();
    tick();
    chk("mb_1010", 32'(data_out), 32'hA);
    tick();
    chk("mb_cnt2", 32'(edge_cnt), 32'd2);

    // Reset asserted mid-pulse, then re-detection after release.
    data_in = '0;
    flush();
    data_in = 4'b0010;
    repeat (LAT) tick();
    tick();
    chk("mid_pulse", 32'(data_out), 32'h2);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_out", 32'(data_out), 32'h0);
    chk("mid_rst_any", 32'(any_out), 32'h0);
    chk("mid_rst_cnt", 32'(edge_cnt), 32'h0);
    tick();
    resetn = 1'b1;
    repeat (LAT) tick();
    tick();
    chk("redetect", 32'(data_out), 32'h2);
    tick();
    chk("redetect_cnt", 32'(edge_cnt), 32'd1);

    // Counter wrap at 2^CW.
    data_in = '0;
    flush();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    repeat (15) begin
      data_in = 4'b0001;
      tick();
      data_in = 4'b0000;
      tick();
    end
    flush();
    chk("cnt_15", 32'(edge_cnt), 32'd15);
    data_in = 4'b0001;
    tick();
    data_in = 4'b0000;
    tick();
    flush();
    chk("cnt_wrap", 32'(edge_cnt), 32'd0);

    // Clear in the same cycle as a pulse drops that edge.
    data_in = 4'b0001;
    tick();
    data_in = 4'b0000;
    flush();
    chk("pre_clr_cnt", 32'(edge_cnt), 32'd1);
    data_in = 4'b0100;
    repeat (LAT) tick();
    tick();
    chk("clr_pulse_seen", 32'(any_out), 32'h1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_priority", 32'(edge_cnt), 32'd0);
    tick();
    chk("clr_no_late", 32'(edge_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rise_edge_detect.md
# rise_edge_detect

Per-bit rising-edge detector that turns a level on each bit of a bus into a one-clock-cycle pulse. The memory/stream interface uses it to convert the level signals `mem_valid` and the stream-read address decode into single-cycle strobes. These strobes drive downstream valid pulses and read-side counters. The block also provides an any-edge summary and a wrapping edge-event counter for debug and throughput measurement.

## Interface
- `DATA_WIDTH`, default 1: number of independent bits monitored; legal values are ≥1.
- `SYNC_STAGES`, default 2: synchroniser depth; used only when `RISE_DETECT_SYNC_EN` is defined; legal values are ≥2.
- `CNT_WIDTH`, default 16: width of the edge-event counter.
- `clk`  in  1  single clock; all flops use the rising edge.
- `resetn`  in  1  reset, asynchronous and active-low.
- `data_in`  in  `DATA_WIDTH`  level inputs; each bit is independent.
- `cnt_clr`  in  1  synchronous clear of `edge_cnt`.
- `data_out`  out  `DATA_WIDTH`  per-bit rising-edge pulses, each one cycle wide.
- `any_out`  out  1  OR-reduction of `data_out`.
- `edge_cnt`  out  `CNT_WIDTH`  number of cycles in which `any_out` was 1, modulo 2^`CNT_WIDTH`.

## Operation
- Per bit there is a sample flop `s` and a history flop `p`.
  - Each clock, `s <= data_in` (or the synchroniser output), then `p <= s`.
- `data_out = s & ~p`, decoded only from flop outputs, so it is glitch-free.
- `any_out = |data_out`.
- A bit that stays high produces exactly one pulse. A bit held low, or a falling edge, produces no pulse.
- Bits are fully independent. Several bits may pulse in the same cycle.
- `edge_cnt` update:
  - Increments by 1 on any clock where `any_out` = 1, regardless of how many bits pulse; it wraps from all-ones to 0.
  - `cnt_clr` = 1 loads 0 and takes priority over the increment, so an edge in the same cycle is not counted.
- Input pulses shorter than one clock period may be missed. The input is sampled only at clock edges.
- A toggle high-low-high across consecutive samples produces two pulses, separated by one low cycle.

## Timing
- Reset (`resetn` = 0), asynchronous:
  - All `s`, `p` and synchroniser flops clear to 0, and `edge_cnt` clears to 0.
  - Therefore `data_out` = 0 and `any_out` = 0 immediately, with no clock needed.
- Reset release with an input already high: the first sampling edge captures 1 while `p` = 0, so that bit produces one pulse.
- Reset asserted mid-pulse: the pulse ends immediately, and the level is re-detected after release.
- Latency without `RISE_DETECT_SYNC_EN`:
  - `data_in` low at edge N−1 and high at edge N gives `data_out` high from edge N to edge N+1.
  - That is 1 cycle from the sampling edge; the pulse width is exactly 1 cycle.
- Latency with the macro defined: `SYNC_STAGES` additional cycles; the pulse width is unchanged.
- `edge_cnt` becomes visible 1 cycle after the pulse it counts.

## Configuration
- `RISE_DETECT_SYNC_EN` defined: each bit of `data_in` passes through a `SYNC_STAGES`-deep flop chain, reset to 0, before reaching `s`. This makes the input safe for asynchronous signals.
- `RISE_DETECT_SYNC_EN` undefined: `data_in` feeds `s` directly. The input must already be synchronous to `clk`.

## Test plan
- Reset and step, macro off, `DATA_WIDTH`=1:
  - Hold `resetn`=0 with `data_in`=1 → `data_out`=0, `edge_cnt`=0.
  - Release → exactly one `data_out` pulse, 1 cycle wide, on the first edge; `edge_cnt` then reads 1.
- Level hold: `data_in` 0→1 held for 10 cycles, then 1→0 → one pulse 1 cycle after the rise, none on the fall.
- Toggle:
  - `data_in` pattern 0,1,0,1 on consecutive edges → pulses in cycles 2 and 4; `edge_cnt`=2.
- Multi-bit, `DATA_WIDTH`=4:
  - `data_in` 0000→0101 → `data_out`=0101 for 1 cycle, `any_out`=1, `edge_cnt` +1.
  - Then 0101→1111 → `data_out`=1010.
- Counter wrap and clear, `CNT_WIDTH`=4:
  - 16 edges → `edge_cnt` wraps to 0.
  - `cnt_clr`=1 in the same cycle as a pulse → `edge_cnt`=0.
- Synchroniser latency, macro on, `SYNC_STAGES`=3: a 0→1 step → pulse appears 3 cycles later than in the macro-off case, still 1 cycle wide.
